// File: rtl/float_to_int_param.sv
// float_to_int_param
//   Multi-cycle float-to-integer converter. A float {sign, exponent, fraction}
//   is unpacked, screened for NaN / infinity / zero / out-of-range, then its
//   significand is shifted one bit per cycle into integer position, rounded
//   according to rm and packed into a signed or unsigned INT_W-bit result
//   with saturation.
//
// Parameters
//   EXP_W        float exponent width
//   MAN_W        float stored-fraction width
//   INT_W        integer result width
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   en             enable; low freezes the FSM and clears the outputs
//   start          request, sampled only while idle
//   input_a        float operand
//   rm             00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
//   signed_mode    1 = two's-complement result, 0 = unsigned result
//   busy           high whenever the FSM is not idle
//   complete       one-cycle pulse, output_z and flags valid
//   output_z       result, held until the next complete
//   flag_invalid   NaN operand
//   flag_overflow  result saturated
//   flag_inexact   result differs from the operand value
module float_to_int_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic [1:0]             rm,
  input  logic                   signed_mode,
  output logic                   busy,
  output logic                   complete,
  output logic [INT_W-1:0]       output_z,
  output logic                   flag_invalid,
  output logic                   flag_overflow,
  output logic                   flag_inexact
);

  localparam int FW    = EXP_W + MAN_W + 1;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EW    = EXP_W + 2;
  // Working magnitude holds the full significand on the right-shift path and
  // every integer bit on the left-shift path, plus one bit for a rounding carry.
  localparam int WW    = ((MAN_W + 1 > INT_W) ? MAN_W + 1 : INT_W) + 1;
  localparam int CNT_W = $clog2(MAN_W + INT_W + 4);

  localparam logic [INT_W-1:0] S_MAX   = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] S_MIN   = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] U_MAX   = {INT_W{1'b1}};
  localparam logic [WW-1:0]    S_MAX_W = {{(WW-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
  localparam logic [WW-1:0]    S_MIN_W = {{(WW-INT_W){1'b0}}, 1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, UNPACK, SPECIAL, SHIFT, ROUND, PACK, DONE
  } state_t;

  state_t                 state;
  logic [FW-1:0]          a_q;
  logic [1:0]             rm_q;
  logic                   sm_q;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_q;
  logic [WW-1:0]          mag;
  logic                   guard;
  logic                   sticky;
  logic [CNT_W-1:0]       cnt;
  logic                   shl;
  logic [INT_W-1:0]       res_z;
  logic                   res_inv;
  logic                   res_ovf;
  logic                   res_inx;

  logic [EXP_W-1:0]       exp_field;
  logic [MAN_W-1:0]       frac_field;
  assign exp_field  = a_q[FW-2:MAN_W];
  assign frac_field = a_q[MAN_W-1:0];

  assign busy = (state != IDLE);

  // Special-case screening and shift planning, evaluated in SPECIAL.
  int               e_int;
  int               shift_n;
  logic             shift_left;
  logic [CNT_W-1:0] cnt_init;
  logic             is_nan;
  logic             is_big;
  logic             is_zero;
  logic [INT_W-1:0] sat_z;

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path leaves it holding its old value and no latch is inferred.
  always_comb begin
    e_int      = int'(exp_q);
    shift_left = 1'b0;
    shift_n    = 0;
    if (e_int > MAN_W) begin
      shift_left = 1'b1;
      shift_n    = e_int - MAN_W;
    end else begin
      shift_n = MAN_W - e_int;
      // Beyond MAN_W+2 steps every significand bit is already in sticky.
      if (shift_n > MAN_W + 2) shift_n = MAN_W + 2;
    end
    cnt_init = CNT_W'(shift_n);
    is_nan   = (&exp_field) && (|frac_field);
    is_big   = (&exp_field) || (e_int >= INT_W);
    is_zero  = ~|exp_field;
    sat_z    = sign_q ? (sm_q ? S_MIN : '0) : (sm_q ? S_MAX : U_MAX);
  end

  // Rounding increment from the guard/sticky bits left by the shifter.
  logic round_inc;
  always_comb begin
    round_inc = 1'b0;
    case (rm_q)
      2'b00:   round_inc = guard & (sticky | mag[0]);
      2'b01:   round_inc = 1'b0;
      2'b10:   round_inc = sign_q & (guard | sticky);
      default: round_inc = ~sign_q & (guard | sticky);
    endcase
  end

  // Range check and sign application on the rounded magnitude.
  logic [INT_W-1:0] mag_lo;
  logic [INT_W-1:0] pack_z;
  logic             pack_ovf;
  logic             pack_inx;
  always_comb begin
    mag_lo   = mag[INT_W-1:0];
    pack_z   = '0;
    pack_ovf = 1'b0;
    pack_inx = res_inx;
    if (sm_q) begin
      if (!sign_q && (mag > S_MAX_W)) begin
        pack_z   = S_MAX;
        pack_ovf = 1'b1;
        pack_inx = 1'b0;
      end else if (sign_q && (mag > S_MIN_W)) begin
        pack_z   = S_MIN;
        pack_ovf = 1'b1;
        pack_inx = 1'b0;
      end else begin
        pack_z = sign_q ? -mag_lo : mag_lo;
      end
    end else begin
      if (sign_q && (|mag)) begin
        pack_z   = '0;
        pack_ovf = 1'b1;
        pack_inx = 1'b0;
      end else if (|mag[WW-1:INT_W]) begin
        pack_z   = U_MAX;
        pack_ovf = 1'b1;
        pack_inx = 1'b0;
      end else begin
        // A negative value that rounded to zero lands here with inexact kept.
        pack_z = mag_lo;
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the values from before the edge, whatever the order.
  // NOTE: only control state and outputs are reset; the datapath registers
  // are always written by an earlier state before any state reads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      complete      <= 1'b0;
      output_z      <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
    end else if (!en) begin
      complete      <= 1'b0;
      output_z      <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
    end else begin
      complete <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= input_a;
            rm_q  <= rm;
            sm_q  <= signed_mode;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q <= a_q[FW-1];
          exp_q  <= {2'b00, exp_field} - EW'(BIAS);
          mag    <= {{(WW-MAN_W-1){1'b0}}, 1'b1, frac_field};
          guard  <= 1'b0;
          sticky <= 1'b0;
          state  <= SPECIAL;
        end
        SPECIAL: begin
          res_inv <= 1'b0;
          res_ovf <= 1'b0;
          res_inx <= 1'b0;
          if (is_nan) begin
            res_z   <= sm_q ? S_MAX : U_MAX;
            res_inv <= 1'b1;
            state   <= DONE;
          end else if (is_big) begin
            res_z   <= sat_z;
            res_ovf <= 1'b1;
            state   <= DONE;
          end else if (is_zero) begin
            res_z   <= '0;
            res_inx <= |frac_field;
            state   <= DONE;
          end else begin
            shl   <= shift_left;
            cnt   <= cnt_init;
            state <= (cnt_init == '0) ? ROUND : SHIFT;
          end
        end
        SHIFT: begin
          if (shl) begin
            mag <= mag << 1;
          end else begin
            mag    <= mag >> 1;
            guard  <= mag[0];
            sticky <= sticky | guard;
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ROUND;
        end
        ROUND: begin
          mag     <= mag + WW'(round_inc);
          res_inx <= guard | sticky;
          state   <= PACK;
        end
        PACK: begin
          res_z   <= pack_z;
          res_ovf <= pack_ovf;
          res_inx <= pack_inx;
          state   <= DONE;
        end
        DONE: begin
          output_z      <= res_z;
          flag_invalid  <= res_inv;
          flag_overflow <= res_ovf;
          flag_inexact  <= res_inx;
          complete      <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_param.sv
// tb_float_to_int_param
//   Scoreboard bench for float_to_int_param at default parameters. Each
//   accepted request pushes the model's result and completion cycle; the
//   monitor pops and compares on every complete pulse.
module tb_float_to_int_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [31:0] input_a;
  logic [1:0]  rm;
  logic        signed_mode;
  logic        busy;
  logic        complete;
  logic [31:0] output_z;
  logic        flag_invalid;
  logic        flag_overflow;
  logic        flag_inexact;

  float_to_int_param dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .start         (start),
    .input_a       (input_a),
    .rm            (rm),
    .signed_mode   (signed_mode),
    .busy          (busy),
    .complete      (complete),
    .output_z      (output_z),
    .flag_invalid  (flag_invalid),
    .flag_overflow (flag_overflow),
    .flag_inexact  (flag_inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  typedef struct {
    logic [31:0] z;
    logic        inv;
    logic        ovf;
    logic        inx;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: value split into integer part and remainder over 2^k.
  function automatic exp_t model(input logic [31:0] a, input logic [1:0] m,
                                 input logic sm, input string tag);
    exp_t        r;
    logic        sgn;
    logic [7:0]  ef;
    logic [22:0] fr;
    longint      sig, ip, rem, half, mag, v;
    int          e, k, n;
    bit          up;
    r.tag = tag; r.z = '0; r.inv = 1'b0; r.ovf = 1'b0; r.inx = 1'b0; r.due = 3;
    sgn = a[31]; ef = a[30:23]; fr = a[22:0];
    e = int'(ef) - 127;
    if (ef == 8'hFF && fr != 0) begin
      r.z = sm ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      r.inv = 1'b1;
    end else if (ef == 8'hFF || e >= 32) begin
      r.z = sgn ? (sm ? 32'h8000_0000 : 32'h0) : (sm ? 32'h7FFF_FFFF : 32'hFFFF_FFFF);
      r.ovf = 1'b1;
    end else if (ef == 8'h00) begin
      r.inx = (fr != 0);
    end else begin
      sig = (longint'(1) << 23) + longint'(fr);
      if (e >= 23) begin
        ip = sig << (e - 23); rem = 0; half = 1; n = e - 23;
      end else begin
        k = 23 - e;
        n = (k > 25) ? 25 : k;
        if (k > 40) begin
          ip = 0; rem = 1; half = 2;
        end else begin
          ip = sig >> k; rem = sig - (ip << k); half = longint'(1) << (k - 1);
        end
      end
      case (m)
        2'b00:   up = (rem > half) || (rem == half && ip[0]);
        2'b01:   up = 1'b0;
        2'b10:   up = sgn && (rem != 0);
        default: up = !sgn && (rem != 0);
      endcase
      mag = ip + (up ? 1 : 0);
      r.inx = (rem != 0);
      r.due = 5 + n;
      if (sm) begin
        v = sgn ? -mag : mag;
        if (v > 64'sd2147483647) begin
          r.z = 32'h7FFF_FFFF; r.ovf = 1'b1; r.inx = 1'b0;
        end else if (v < -64'sd2147483648) begin
          r.z = 32'h8000_0000; r.ovf = 1'b1; r.inx = 1'b0;
        end else begin
          r.z = v[31:0];
        end
      end else begin
        if (sgn && mag != 0) begin
          r.z = 32'h0; r.ovf = 1'b1; r.inx = 1'b0;
        end else if (mag > 64'sd4294967295) begin
          r.z = 32'hFFFF_FFFF; r.ovf = 1'b1; r.inx = 1'b0;
        end else begin
          r.z = mag[31:0];
        end
      end
    end
    return r;
  endfunction

  // Monitor: every complete pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && complete) begin
      if (sb.size() == 0) begin
        check("unexpected_complete", complete, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_z"},     output_z,      mon_e.z);
        check({mon_e.tag, "_inv"},   flag_invalid,  mon_e.inv);
        check({mon_e.tag, "_ovf"},   flag_overflow, mon_e.ovf);
        check({mon_e.tag, "_inx"},   flag_inexact,  mon_e.inx);
        check({mon_e.tag, "_cycle"}, cyc,           mon_e.due);
      end
    end
  end

  // Present one request; extra accounts for cycles the bench will hold en low.
  task automatic launch(input string tag, input logic [31:0] a, input logic [1:0] m,
                        input logic sm, input int extra);
    exp_t e;
    @(negedge clk);
    input_a = a; rm = m; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(a, m, sm, tag);
    e.due = cyc + e.due + extra;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  m;
    logic        sm;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  exp_t last_e;

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0;
    input_a = '0; rm = 2'b00; signed_mode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     busy,          1'b0);
    check("rst_complete", complete,      1'b0);
    check("rst_z",        output_z,      32'h0);
    check("rst_flags",    {flag_invalid, flag_overflow, flag_inexact}, 3'b000);
    rst = 1'b0;

    vecs = '{
      '{32'h4060_0000, 2'b00, 1'b1, "p3p5_rne"},
      '{32'h4020_0000, 2'b00, 1'b1, "p2p5_rne"},
      '{32'h4020_0000, 2'b01, 1'b1, "p2p5_rtz"},
      '{32'h4020_0000, 2'b10, 1'b1, "p2p5_rdn"},
      '{32'h4020_0000, 2'b11, 1'b1, "p2p5_rup"},
      '{32'hC020_0000, 2'b10, 1'b1, "m2p5_rdn"},
      '{32'h4F00_0000, 2'b00, 1'b1, "p2e31_s"},
      '{32'h4F00_0000, 2'b00, 1'b0, "p2e31_u"},
      '{32'hCF00_0000, 2'b00, 1'b1, "m2e31_s"},
      '{32'hCF00_0001, 2'b00, 1'b1, "m2e31big_s"},
      '{32'h7FC0_0000, 2'b00, 1'b1, "nan_s"},
      '{32'hBF00_0000, 2'b01, 1'b0, "m0p5_rtz_u"},
      '{32'hBF00_0000, 2'b10, 1'b0, "m0p5_rdn_u"},
      '{32'hBF00_0000, 2'b10, 1'b1, "m0p5_rdn_s"},
      '{32'hBF00_0000, 2'b11, 1'b1, "m0p5_rup_s"},
      '{32'h0000_0000, 2'b00, 1'b1, "zero"},
      '{32'h0000_0001, 2'b11, 1'b1, "denorm"},
      '{32'h7F80_0000, 2'b00, 1'b0, "pinf_u"},
      '{32'hFF80_0000, 2'b00, 1'b1, "minf_s"},
      '{32'h4F80_0000, 2'b00, 1'b0, "p2e32_u"},
      '{32'h4B00_0001, 2'b00, 1'b1, "noshift"},
      '{32'h3F80_0000, 2'b00, 1'b0, "one_u"},
      '{32'h3FC0_0000, 2'b00, 1'b1, "p1p5_rne"},
      '{32'hBFC0_0000, 2'b11, 1'b1, "m1p5_rup"},
      '{32'h3380_0000, 2'b11, 1'b1, "tiny_rup"}
    };
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.a   = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 160)), 23'($urandom)};
      v.m   = 2'($urandom_range(0, 3));
      v.sm  = 1'($urandom_range(0, 1));
      v.tag = $sformatf("rand%0d", i);
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      launch(vecs[i].tag, vecs[i].a, vecs[i].m, vecs[i].sm, 0);
      wait_done();
    end

    // Result stays on output_z after the pulse.
    last_e = model(vecs[vecs.size()-1].a, vecs[vecs.size()-1].m,
                   vecs[vecs.size()-1].sm, "hold");
    repeat (3) @(negedge clk);
    check("hold_z",    output_z, last_e.z);
    check("idle_busy", busy,     1'b0);

    // Start pulses while busy must be ignored.
    launch("busy_start", 32'h4060_0000, 2'b00, 1'b1, 0);
    @(negedge clk);
    check("busy_high", busy, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      input_a = 32'h7FC0_0000;
      start   = busy;
    end
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Enable low mid-conversion: outputs clear, FSM resumes after 4 cycles.
    launch("en_pause", 32'h4060_0000, 2'b00, 1'b1, 4);
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en0_z",     output_z, 32'h0);
    check("en0_flags", {flag_invalid, flag_overflow, flag_inexact}, 3'b000);
    check("en0_busy",  busy, 1'b1);
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_done();

    // Reset during SHIFT aborts without a complete pulse.
    @(negedge clk);
    input_a = 32'h4060_0000; rm = 2'b00; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",     busy,     1'b0);
    check("abort_complete", complete, 1'b0);
    check("abort_z",        output_z, 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
